// File: rtl/interrupt_arbiter.sv
// Edge-capturing interrupt arbiter: latches rising edges into pending bits,
// dispatches the lowest-index enabled source once, and blocks until ISR return.
module interrupt_arbiter #(
    parameter int NUM_SRC    = 8,
    parameter int ID_W       = 3,
    parameter int VEC_BASE   = 500,
    parameter int VEC_STRIDE = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [NUM_SRC-1:0] irq_mask,
    input  logic               stall,
    input  logic               return_from_isr,
    output logic               irq_req,
    output logic [31:0]        irq_vector,
    output logic [ID_W-1:0]    irq_id,
    output logic               in_isr,
    output logic [NUM_SRC-1:0] pending
);

    typedef enum logic [1:0] {IDLE, DISPATCH, IN_ISR} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [NUM_SRC-1:0] r_prev;
    logic [NUM_SRC-1:0] r_pending;
    logic [ID_W-1:0]    r_id;
    logic [31:0]        r_vector;

    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_eligible;
    logic [NUM_SRC-1:0] w_clr;
    logic [ID_W-1:0]    w_pick;
    logic               w_found;
    logic               w_load;
    logic               w_done;

    assign w_rise     = irq_src & ~r_prev;
    assign w_eligible = r_pending & irq_mask;

    // Scan high to low so the lowest eligible index is the last one written.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_found = 1'b1;
                w_pick  = ID_W'(i);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found && !stall) begin
                    w_load = 1'b1;
                    w_next = DISPATCH;
                end
            end
            DISPATCH: begin
                if (!stall) begin
                    w_done = 1'b1;
                    w_next = IN_ISR;
                end
            end
            IN_ISR: begin
                if (return_from_isr) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_clr = '0;
        if (w_done) w_clr[r_id] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_prev    <= '0;
            r_pending <= '0;
            r_id      <= '0;
            r_vector  <= '0;
        end else begin
            r_state   <= w_next;
            r_prev    <= irq_src;
            // A new edge on the bit being cleared keeps it pending.
            r_pending <= (r_pending & ~w_clr) | w_rise;
            if (w_load) begin
                r_id     <= w_pick;
                r_vector <= 32'(VEC_BASE) + 32'(w_pick) * 32'(VEC_STRIDE);
            end
        end
    end

    assign irq_req    = (r_state == DISPATCH);
    assign in_isr     = (r_state == IN_ISR);
    assign irq_id     = r_id;
    assign irq_vector = r_vector;
    assign pending    = r_pending;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed bench for interrupt_arbiter: a vector table for the basic flow
// plus hand sequences for masking, stall, busy edges and async reset.
module tb_interrupt_arbiter;

    logic        clk;
    logic        reset;
    logic [7:0]  irq_src;
    logic [7:0]  irq_mask;
    logic        stall;
    logic        return_from_isr;
    logic        irq_req;
    logic [31:0] irq_vector;
    logic [2:0]  irq_id;
    logic        in_isr;
    logic [7:0]  pending;

    int checks   = 0;
    int failures = 0;

    interrupt_arbiter #(
        .NUM_SRC(8), .ID_W(3), .VEC_BASE(500), .VEC_STRIDE(16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .irq_src         (irq_src),
        .irq_mask        (irq_mask),
        .stall           (stall),
        .return_from_isr (return_from_isr),
        .irq_req         (irq_req),
        .irq_vector      (irq_vector),
        .irq_id          (irq_id),
        .in_isr          (in_isr),
        .pending         (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  src;
        logic [7:0]  mask;
        logic        stl;
        logic        ret;
        logic        req;
        logic [31:0] vec;
        logic [2:0]  id;
        logic        isr;
        logic [7:0]  pend;
    } vec_t;

    vec_t vtab[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic req, input logic [31:0] vec,
                           input logic [2:0] id, input logic isr, input logic [7:0] pend);
        chk({tag, ".irq_req"},    32'(irq_req),    32'(req));
        chk({tag, ".irq_vector"}, irq_vector,      vec);
        chk({tag, ".irq_id"},     32'(irq_id),     32'(id));
        chk({tag, ".in_isr"},     32'(in_isr),     32'(isr));
        chk({tag, ".pending"},    32'(pending),    32'(pend));
    endtask

    // Advance one posedge and settle just after it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            src    mask   st  ret  req  vec  id  isr pend
        vtab[0]  = '{8'h08, 8'hFF, 0, 0,   0,   0,   0, 0,  8'h08};
        vtab[1]  = '{8'h00, 8'hFF, 0, 0,   1, 548,   3, 0,  8'h08};
        vtab[2]  = '{8'h00, 8'hFF, 0, 0,   0, 548,   3, 1,  8'h00};
        vtab[3]  = '{8'h00, 8'hFF, 0, 0,   0, 548,   3, 1,  8'h00};
        vtab[4]  = '{8'h00, 8'hFF, 0, 1,   0, 548,   3, 0,  8'h00};
        vtab[5]  = '{8'h24, 8'hFF, 0, 0,   0, 548,   3, 0,  8'h24};
        vtab[6]  = '{8'h00, 8'hFF, 0, 0,   1, 532,   2, 0,  8'h24};
        vtab[7]  = '{8'h00, 8'hFF, 0, 0,   0, 532,   2, 1,  8'h20};
        vtab[8]  = '{8'h00, 8'hFF, 0, 1,   0, 532,   2, 0,  8'h20};
        vtab[9]  = '{8'h00, 8'hFF, 0, 0,   1, 580,   5, 0,  8'h20};
        vtab[10] = '{8'h00, 8'hFF, 0, 0,   0, 580,   5, 1,  8'h00};
        vtab[11] = '{8'h00, 8'hFF, 0, 1,   0, 580,   5, 0,  8'h00};
        vtab[12] = '{8'h01, 8'hFE, 0, 0,   0, 580,   5, 0,  8'h01};

        reset = 1'b1; irq_src = '0; irq_mask = 8'hFF; stall = 1'b0; return_from_isr = 1'b0;
        tick; tick;
        chk_all("reset", 0, 0, 0, 0, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        // Basic flow: single source, priority, return latency, mask setup
        for (int i = 0; i < 13; i++) begin
            irq_src = vtab[i].src; irq_mask = vtab[i].mask;
            stall = vtab[i].stl;   return_from_isr = vtab[i].ret;
            tick;
            chk_all($sformatf("vec%0d", i), vtab[i].req, vtab[i].vec, vtab[i].id,
                    vtab[i].isr, vtab[i].pend);
        end

        // Masked source stays pending and is never dispatched
        irq_src = '0;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk($sformatf("mask_hold%0d.irq_req", i), 32'(irq_req), 0);
            chk($sformatf("mask_hold%0d.pending", i), 32'(pending), 32'h01);
        end
        irq_mask = 8'hFF;
        tick; chk_all("mask_en_dispatch", 1, 500, 0, 0, 8'h01);
        tick; chk_all("mask_en_isr",      0, 500, 0, 1, 8'h00);
        return_from_isr = 1'b1;
        tick; chk_all("mask_en_ret",      0, 500, 0, 0, 8'h00);
        return_from_isr = 1'b0;

        // Stall blocks dispatch, then freezes an active dispatch
        stall = 1'b1; irq_src = 8'h02;
        tick; chk_all("stall_cap", 0, 500, 0, 0, 8'h02);
        irq_src = '0;
        for (int i = 0; i < 3; i++) begin
            tick; chk_all($sformatf("stall_idle%0d", i), 0, 500, 0, 0, 8'h02);
        end
        stall = 1'b0;
        tick; chk_all("stall_disp", 1, 516, 1, 0, 8'h02);
        stall = 1'b1; irq_src = 8'h01;
        tick; chk_all("stall_hold0", 1, 516, 1, 0, 8'h03);
        irq_src = '0; irq_mask = 8'h00;
        for (int i = 1; i < 3; i++) begin
            tick; chk_all($sformatf("stall_hold%0d", i), 1, 516, 1, 0, 8'h03);
        end
        stall = 1'b0;
        tick; chk_all("stall_rel_isr", 0, 516, 1, 1, 8'h01);
        tick; chk_all("stall_rel_isr2", 0, 516, 1, 1, 8'h01);
        return_from_isr = 1'b1; irq_mask = 8'hFF;
        tick; chk_all("stall_ret", 0, 516, 1, 0, 8'h01);
        return_from_isr = 1'b0;
        tick; chk_all("stall_next_disp", 1, 500, 0, 0, 8'h01);
        tick; chk_all("stall_next_isr",  0, 500, 0, 1, 8'h00);
        return_from_isr = 1'b1;
        tick;
        return_from_isr = 1'b0;

        // Edges arriving while an ISR is in service
        irq_src = 8'h40;
        tick; chk_all("busy_cap6", 0, 500, 0, 0, 8'h40);
        irq_src = '0;
        tick; chk_all("busy_disp6", 1, 596, 6, 0, 8'h40);
        tick; chk_all("busy_isr6",  0, 596, 6, 1, 8'h00);
        for (int i = 0; i < 2; i++) begin
            irq_src = 8'h10;
            tick; chk_all($sformatf("busy_hi%0d", i), 0, 596, 6, 1, 8'h10);
            irq_src = '0;
            tick; chk_all($sformatf("busy_lo%0d", i), 0, 596, 6, 1, 8'h10);
        end
        return_from_isr = 1'b1;
        tick; chk_all("busy_ret", 0, 596, 6, 0, 8'h10);
        return_from_isr = 1'b0;
        tick; chk_all("busy_disp4", 1, 564, 4, 0, 8'h10);
        tick; chk_all("busy_isr4",  0, 564, 4, 1, 8'h00);
        tick; chk_all("busy_single", 0, 564, 4, 1, 8'h00);
        return_from_isr = 1'b1;
        tick; chk_all("busy_ret4", 0, 564, 4, 0, 8'h00);
        tick; chk_all("idle_ret_ignored", 0, 564, 4, 0, 8'h00);
        return_from_isr = 1'b0;
        tick; chk_all("idle_after_ret", 0, 564, 4, 0, 8'h00);

        // Asynchronous reset while in service with a pending bit
        irq_src = 8'h02;
        tick;
        irq_src = '0;
        tick; chk_all("rst_disp", 1, 516, 1, 0, 8'h02);
        tick;
        irq_src = 8'h10;
        tick;
        irq_src = '0;
        tick; chk_all("rst_pre", 0, 516, 1, 1, 8'h10);
        #3 reset = 1'b1;
        #1 chk_all("rst_async", 0, 0, 0, 0, 8'h00);
        #2 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick; chk_all($sformatf("rst_after%0d", i), 0, 0, 0, 0, 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
